reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: one single-entry buffer per requester (ALU, MEM),
// oldest-first grant with MEM winning ties, and pending-write hazard flags for decode.
module reg_wb_arbiter (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [2:0]  alu_op,
    input  logic [2:0]  alu_addr,
    input  logic [15:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [2:0]  mem_op,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] mem_data,
    output logic [2:0]  reg_op,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    input  logic [2:0]  A_addr,
    input  logic [2:0]  B_addr,
    output logic        hz_A,
    output logic        hz_B,
    output logic        hz_T,
    output logic        hz_SP,
    output logic        hz_IH,
    output logic        hz_RA
);

    localparam int MEM = 0;
    localparam int ALU = 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_REG = 3'b001;
    localparam logic [2:0] OP_T   = 3'b010;
    localparam logic [2:0] OP_SP  = 3'b011;
    localparam logic [2:0] OP_IH  = 3'b100;
    localparam logic [2:0] OP_RA  = 3'b101;

    // Requester-indexed views of the two input ports.
    logic [1:0]  in_valid;
    logic [2:0]  in_op   [2];
    logic [2:0]  in_addr [2];
    logic [15:0] in_data [2];

    // Buffer state. age_reg[i]=1 means entry i is strictly older than the other valid entry.
    logic [1:0]  valid_reg;
    logic [1:0]  age_reg;
    logic [2:0]  op_reg   [2];
    logic [2:0]  addr_reg [2];
    logic [15:0] data_reg [2];

    logic [1:0] grant;
    logic [1:0] ready;
    logic [1:0] load;
    logic [1:0] keep;
    logic [1:0] valid_next;
    logic [1:0] age_next;

    function automatic logic is_write(input logic [2:0] op);
        return (op >= OP_REG) && (op <= OP_RA);
    endfunction

    assign in_valid      = {alu_valid, mem_valid};
    assign in_op[MEM]    = mem_op;
    assign in_op[ALU]    = alu_op;
    assign in_addr[MEM]  = mem_addr;
    assign in_addr[ALU]  = alu_addr;
    assign in_data[MEM]  = mem_data;
    assign in_data[ALU]  = alu_data;

    // Oldest valid entry wins; entries captured on the same edge carry no age, so MEM wins.
    always_comb begin
        grant = 2'b00;
        if (valid_reg[MEM] && valid_reg[ALU]) begin
            if (age_reg[ALU]) begin
                grant[ALU] = 1'b1;
            end else begin
                grant[MEM] = 1'b1;
            end
        end else if (valid_reg[MEM]) begin
            grant[MEM] = 1'b1;
        end else if (valid_reg[ALU]) begin
            grant[ALU] = 1'b1;
        end
    end

    always_comb begin
        ready      = 2'b00;
        load       = 2'b00;
        keep       = 2'b00;
        valid_next = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ready[i]      = !valid_reg[i] || grant[i];
            load[i]       = in_valid[i] && ready[i] && is_write(in_op[i]);
            keep[i]       = valid_reg[i] && !grant[i];
            valid_next[i] = load[i] || keep[i];
        end
        // A held entry becomes the older one when the other buffer takes a fresh entry.
        age_next[MEM] = keep[MEM] && (load[ALU] || (keep[ALU] && age_reg[MEM]));
        age_next[ALU] = keep[ALU] && (load[MEM] || (keep[MEM] && age_reg[ALU]));
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            valid_reg <= 2'b00;
            age_reg   <= 2'b00;
        end else begin
            valid_reg <= valid_next;
            age_reg   <= age_next;
        end
    end

    // Payload needs no reset: it is only observed through valid_reg.
    always_ff @(posedge clk_50MHz) begin
        for (int i = 0; i < 2; i++) begin
            if (load[i]) begin
                op_reg[i]   <= in_op[i];
                addr_reg[i] <= in_addr[i];
                data_reg[i] <= in_data[i];
            end
        end
    end

    assign alu_ready = ready[ALU];
    assign mem_ready = ready[MEM];

    always_comb begin
        reg_op  = OP_NOP;
        wb_addr = 3'd0;
        wb_data = 16'd0;
        if (grant[ALU]) begin
            reg_op  = op_reg[ALU];
            wb_addr = addr_reg[ALU];
            wb_data = data_reg[ALU];
        end else if (grant[MEM]) begin
            reg_op  = op_reg[MEM];
            wb_addr = addr_reg[MEM];
            wb_data = data_reg[MEM];
        end
    end

    // Hazards cover every held entry, including the one being written this cycle.
    always_comb begin
        hz_A  = 1'b0;
        hz_B  = 1'b0;
        hz_T  = 1'b0;
        hz_SP = 1'b0;
        hz_IH = 1'b0;
        hz_RA = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (valid_reg[i]) begin
                if (op_reg[i] == OP_REG && addr_reg[i] == A_addr) hz_A = 1'b1;
                if (op_reg[i] == OP_REG && addr_reg[i] == B_addr) hz_B = 1'b1;
                if (op_reg[i] == OP_T)  hz_T  = 1'b1;
                if (op_reg[i] == OP_SP) hz_SP = 1'b1;
                if (op_reg[i] == OP_IH) hz_IH = 1'b1;
                if (op_reg[i] == OP_RA) hz_RA = 1'b1;
            end
        end
    end

endmodule
